// File: rtl/minesweeper_pkg.sv
// Shared definitions for the Minesweeper board controller.
//   - command op codes and game_state encodings
//   - cell field widths and rd_cell bit positions
//   - controller FSM state type and encodings
//   - neighbour scan direction helper
package minesweeper_pkg;

   // Command op codes (cmd_op)
   localparam logic [1:0] OP_NOP      = 2'd0;
   localparam logic [1:0] OP_REVEAL   = 2'd1;
   localparam logic [1:0] OP_FLAG     = 2'd2;
   localparam logic [1:0] OP_NEW_GAME = 2'd3;

   // game_state encodings
   localparam logic [1:0] GS_IDLE = 2'd0;
   localparam logic [1:0] GS_PLAY = 2'd1;
   localparam logic [1:0] GS_WON  = 2'd2;
   localparam logic [1:0] GS_LOST = 2'd3;

   // rd_cell layout: {revealed, flagged, mine, count[3:0]}
   localparam int CELL_W       = 7;
   localparam int CNT_W        = 4;
   localparam int BIT_REVEALED = 6;
   localparam int BIT_FLAGGED  = 5;
   localparam int BIT_MINE     = 4;

   // Controller FSM
   typedef logic [2:0] fsm_state_t;
   localparam fsm_state_t S_IDLE  = 3'd0;
   localparam fsm_state_t S_CLEAR = 3'd1;
   localparam fsm_state_t S_PLACE = 3'd2;
   localparam fsm_state_t S_PLAY  = 3'd3;
   localparam fsm_state_t S_SCAN  = 3'd4;
   localparam fsm_state_t S_WRITE = 3'd5;
   localparam fsm_state_t S_DONE  = 3'd6;

   // Neighbour visited at each scan step, order NW, N, NE, W, E, SW, S, SE.
   // Returns {x_dec, x_inc, y_dec, y_inc}; y grows downwards.
   function automatic logic [3:0] nb_dir(input logic [2:0] step);
      logic [3:0] d;
      case (step)
         3'd0:    d = 4'b1010; // NW
         3'd1:    d = 4'b0010; // N
         3'd2:    d = 4'b0110; // NE
         3'd3:    d = 4'b1000; // W
         3'd4:    d = 4'b0100; // E
         3'd5:    d = 4'b1001; // SW
         3'd6:    d = 4'b0001; // S
         default: d = 4'b0101; // SE
      endcase
      return d;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
// Free-running: advances every clock from reset.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-low reset (loads SEED)
//   state out  current 16-bit LFSR value
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] state
);

   logic [15:0] state_reg;
   logic        fb;

   // Right-shifting form: taps 16,14,13,11 land on bits 0,2,3,5.
   assign fb = state_reg[0] ^ state_reg[2] ^ state_reg[3] ^ state_reg[5];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= SEED;
      end else begin
         state_reg <= {fb, state_reg[15:1]};
      end
   end

   assign state = state_reg;

endmodule

// File: rtl/board_ctrl.sv
// Minesweeper game controller: owns per-cell state (mine, revealed, flagged,
// neighbour count), places mines from a free-running LFSR, serialises
// REVEAL / FLAG / NEW_GAME commands and computes neighbour counts one
// neighbour per cycle.
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   cmd_valid   in   command request
//   cmd_ready   out  command accepted this cycle when high with cmd_valid
//   cmd_op      in   0 NOP, 1 REVEAL, 2 FLAG, 3 NEW_GAME
//   cmd_x/y     in   target cell
//   rd_x/y      in   renderer query cell
//   rd_cell     out  {revealed, flagged, mine, count[3:0]}, combinational
//   game_state  out  0 IDLE, 1 PLAY, 2 WON, 3 LOST
//   flags_left  out  two's complement, NUM_MINES minus flags placed
//   busy        out  internal sequence running (= !cmd_ready)
module board_ctrl
   import minesweeper_pkg::*;
#(
   parameter int          GRID_W    = 8,
   parameter int          GRID_H    = 8,
   parameter int          NUM_MINES = 10,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_op,
   input  logic [$clog2(GRID_W)-1:0] cmd_x,
   input  logic [$clog2(GRID_H)-1:0] cmd_y,
   input  logic [$clog2(GRID_W)-1:0] rd_x,
   input  logic [$clog2(GRID_H)-1:0] rd_y,
   output logic [6:0]                rd_cell,
   output logic [1:0]                game_state,
   output logic [7:0]                flags_left,
   output logic                      busy
);

   localparam int XW    = $clog2(GRID_W);
   localparam int YW    = $clog2(GRID_H);
   localparam int IW    = XW + YW;
   localparam int CELLS = GRID_W * GRID_H;
   localparam int CW    = $clog2(CELLS + 1);

   localparam logic [CW-1:0] MINES_C  = CW'(NUM_MINES);
   localparam logic [CW-1:0] SAFE_C   = CW'(CELLS - NUM_MINES);
   localparam logic [IW-1:0] LAST_IDX = IW'(CELLS - 1);
   localparam logic [XW-1:0] X_MAX    = XW'(GRID_W - 1);
   localparam logic [YW-1:0] Y_MAX    = YW'(GRID_H - 1);

   // ---------------- LFSR ----------------
   logic [15:0]   lfsr;
   logic [IW-1:0] place_idx;
   logic          unused_lfsr;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .state (lfsr)
   );

   assign place_idx   = lfsr[IW-1:0];
   assign unused_lfsr = ^lfsr[15:IW];

   // ---------------- control registers ----------------
   fsm_state_t    state_reg, state_next;
   logic [1:0]    game_reg, game_next;
   logic [IW-1:0] clr_idx_reg, clr_idx_next;
   logic [CW-1:0] placed_reg, placed_next, placed_inc;
   logic [2:0]    scan_reg, scan_next;
   logic [3:0]    sum_reg, sum_next;
   logic [XW-1:0] tx_reg, tx_next;
   logic [YW-1:0] ty_reg, ty_next;
   logic [CW-1:0] revealed_cnt_reg, revealed_cnt_next, rev_inc;
   logic [7:0]    flag_cnt_reg, flag_cnt_next;

   // ---------------- cell storage ----------------
   logic [CELLS-1:0] mine_vec, rev_vec, flag_vec;
   logic [3:0]       cnt_mem [CELLS];

   // Single write port into the cell array, driven by the FSM.
   logic [IW-1:0] cell_idx;
   logic          op_clear, op_place, op_reveal, op_flag, op_count;

   genvar gi;
   generate
      for (gi = 0; gi < CELLS; gi++) begin : g_cell
         logic       mine_reg, rev_reg, flag_reg;
         logic [3:0] cnt_reg;
         logic       sel;

         assign sel = (cell_idx == IW'(gi));

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               mine_reg <= 1'b0;
               rev_reg  <= 1'b0;
               flag_reg <= 1'b0;
               cnt_reg  <= 4'd0;
            end else if (sel) begin
               if (op_clear) begin
                  mine_reg <= 1'b0;
                  rev_reg  <= 1'b0;
                  flag_reg <= 1'b0;
                  cnt_reg  <= 4'd0;
               end else begin
                  if (op_place)  mine_reg <= 1'b1;
                  if (op_reveal) rev_reg  <= 1'b1;
                  if (op_flag)   flag_reg <= ~flag_reg;
                  if (op_count)  cnt_reg  <= sum_reg;
               end
            end
         end

         assign mine_vec[gi] = mine_reg;
         assign rev_vec[gi]  = rev_reg;
         assign flag_vec[gi] = flag_reg;
         assign cnt_mem[gi]  = cnt_reg;
      end
   endgenerate

   // ---------------- read port ----------------
   logic [IW-1:0] rd_idx;
   assign rd_idx  = {rd_y, rd_x};
   assign rd_cell = {rev_vec[rd_idx], flag_vec[rd_idx], mine_vec[rd_idx], cnt_mem[rd_idx]};

   // ---------------- neighbour scan ----------------
   logic [3:0]    dir;
   logic [XW-1:0] nb_x;
   logic [YW-1:0] nb_y;
   logic          nb_on, nb_hit;

   always_comb begin
      dir  = nb_dir(scan_reg);
      nb_x = tx_reg;
      nb_y = ty_reg;
      if (dir[3])      nb_x = tx_reg - 1'b1;
      else if (dir[2]) nb_x = tx_reg + 1'b1;
      if (dir[1])      nb_y = ty_reg - 1'b1;
      else if (dir[0]) nb_y = ty_reg + 1'b1;
      // Off-board neighbours would wrap; mask them instead.
      nb_on  = !(dir[3] && tx_reg == '0) && !(dir[2] && tx_reg == X_MAX) &&
               !(dir[1] && ty_reg == '0) && !(dir[0] && ty_reg == Y_MAX);
      nb_hit = nb_on && mine_vec[{nb_y, nb_x}];
   end

   // ---------------- FSM ----------------
   logic          accept;
   logic [IW-1:0] cmd_idx, tgt_idx;

   assign cmd_ready  = (state_reg == S_IDLE) || (state_reg == S_PLAY) || (state_reg == S_DONE);
   assign busy       = !cmd_ready;
   assign accept     = cmd_valid && cmd_ready;
   assign cmd_idx    = {cmd_y, cmd_x};
   assign tgt_idx    = {ty_reg, tx_reg};
   assign placed_inc = placed_reg + 1'b1;
   assign rev_inc    = revealed_cnt_reg + 1'b1;
   assign game_state = game_reg;
   assign flags_left = 8'(NUM_MINES) - flag_cnt_reg;

   always_comb begin
      state_next        = state_reg;
      game_next         = game_reg;
      clr_idx_next      = clr_idx_reg;
      placed_next       = placed_reg;
      scan_next         = scan_reg;
      sum_next          = sum_reg;
      tx_next           = tx_reg;
      ty_next           = ty_reg;
      revealed_cnt_next = revealed_cnt_reg;
      flag_cnt_next     = flag_cnt_reg;
      cell_idx          = cmd_idx;
      op_clear          = 1'b0;
      op_place          = 1'b0;
      op_reveal         = 1'b0;
      op_flag           = 1'b0;
      op_count          = 1'b0;

      case (state_reg)
         S_IDLE, S_DONE: begin
            if (accept && cmd_op == OP_NEW_GAME) begin
               state_next   = S_CLEAR;
               clr_idx_next = '0;
               game_next    = GS_IDLE;
            end
         end
         S_PLAY: begin
            if (accept) begin
               case (cmd_op)
                  OP_REVEAL: begin
                     if (!rev_vec[cmd_idx] && !flag_vec[cmd_idx]) begin
                        if (mine_vec[cmd_idx]) begin
                           op_reveal  = 1'b1;
                           game_next  = GS_LOST;
                           state_next = S_DONE;
                        end else begin
                           tx_next    = cmd_x;
                           ty_next    = cmd_y;
                           scan_next  = 3'd0;
                           sum_next   = 4'd0;
                           state_next = S_SCAN;
                        end
                     end
                  end
                  OP_FLAG: begin
                     if (!rev_vec[cmd_idx]) begin
                        op_flag       = 1'b1;
                        flag_cnt_next = flag_vec[cmd_idx] ? flag_cnt_reg - 8'd1
                                                          : flag_cnt_reg + 8'd1;
                     end
                  end
                  OP_NEW_GAME: begin
                     state_next   = S_CLEAR;
                     clr_idx_next = '0;
                     game_next    = GS_IDLE;
                  end
                  default: ;
               endcase
            end
         end
         S_CLEAR: begin
            cell_idx          = clr_idx_reg;
            op_clear          = 1'b1;
            clr_idx_next      = clr_idx_reg + 1'b1;
            revealed_cnt_next = '0;
            flag_cnt_next     = 8'd0;
            placed_next       = '0;
            if (clr_idx_reg == LAST_IDX) state_next = S_PLACE;
         end
         S_PLACE: begin
            // A draw landing on an existing mine simply retries next cycle.
            cell_idx = place_idx;
            if (!mine_vec[place_idx]) begin
               op_place    = 1'b1;
               placed_next = placed_inc;
               if (placed_inc == MINES_C) begin
                  state_next = S_PLAY;
                  game_next  = GS_PLAY;
               end
            end
         end
         S_SCAN: begin
            sum_next  = sum_reg + {3'b000, nb_hit};
            scan_next = scan_reg + 3'd1;
            if (scan_reg == 3'd7) state_next = S_WRITE;
         end
         S_WRITE: begin
            cell_idx          = tgt_idx;
            op_count          = 1'b1;
            op_reveal         = 1'b1;
            revealed_cnt_next = rev_inc;
            if (rev_inc == SAFE_C) begin
               game_next  = GS_WON;
               state_next = S_DONE;
            end else begin
               state_next = S_PLAY;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg        <= S_IDLE;
         game_reg         <= GS_IDLE;
         clr_idx_reg      <= '0;
         placed_reg       <= '0;
         scan_reg         <= 3'd0;
         sum_reg          <= 4'd0;
         tx_reg           <= '0;
         ty_reg           <= '0;
         revealed_cnt_reg <= '0;
         flag_cnt_reg     <= 8'd0;
      end else begin
         state_reg        <= state_next;
         game_reg         <= game_next;
         clr_idx_reg      <= clr_idx_next;
         placed_reg       <= placed_next;
         scan_reg         <= scan_next;
         sum_reg          <= sum_next;
         tx_reg           <= tx_next;
         ty_reg           <= ty_next;
         revealed_cnt_reg <= revealed_cnt_next;
         flag_cnt_reg     <= flag_cnt_next;
      end
   end

endmodule

// File: tb/tb_board_ctrl.sv
// Scoreboard bench for board_ctrl (8x8, 10 mines, default seed).
// Stimulus pushes expected values into a queue; the monitor pops and
// compares them against the DUT on the falling clock edge.
module tb_board_ctrl;
   import minesweeper_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'd0;
   logic [2:0] cmd_x = 3'd0, cmd_y = 3'd0;
   logic [2:0] rd_x = 3'd0, rd_y = 3'd0;
   logic [6:0] rd_cell;
   logic [1:0] game_state;
   logic [7:0] flags_left;
   logic       busy;

   board_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_x      (cmd_x),
      .cmd_y      (cmd_y),
      .rd_x       (rd_x),
      .rd_y       (rd_y),
      .rd_cell    (rd_cell),
      .game_state (game_state),
      .flags_left (flags_left),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   localparam int K_STATE = 0, K_READY = 1, K_BUSY = 2, K_FLAGS = 3,
                  K_CELL = 4, K_EQ = 5, K_GE = 6;

   typedef struct {
      int    kind;
      string name;
      int    exp;
      int    obs;
   } item_t;

   item_t sb[$];
   int    tests = 0;
   int    fails = 0;
   int    mine_map [8][8];
   int    revd     [8][8];

   // ---------------- monitor ----------------
   item_t mon_it;
   int    mon_obs;
   logic  mon_ok;
   initial begin
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            mon_it = sb.pop_front();
            case (mon_it.kind)
               K_STATE: mon_obs = int'(game_state);
               K_READY: mon_obs = int'(cmd_ready);
               K_BUSY:  mon_obs = int'(busy);
               K_FLAGS: mon_obs = int'(flags_left);
               K_CELL:  mon_obs = int'(rd_cell);
               default: mon_obs = mon_it.obs;
            endcase
            mon_ok = (mon_it.kind == K_GE) ? (mon_obs >= mon_it.exp) : (mon_obs == mon_it.exp);
            tests++;
            if (mon_ok) begin
               $display("[TB] %0t check %s ok: got %0d", $time, mon_it.name, mon_obs);
            end else begin
               fails++;
               $display("[TB] %0t FAIL %s: got %0d, required %s%0d", $time, mon_it.name,
                        mon_obs, (mon_it.kind == K_GE) ? ">= " : "", mon_it.exp);
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input int kind, input string name, input int exp, input int obs = 0);
      item_t it;
      it.kind = kind; it.name = name; it.exp = exp; it.obs = obs;
      sb.push_back(it);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 20) begin
         step();
         n++;
      end
      if (sb.size() > 0) begin
         $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
         $fatal(1, "scoreboard stalled");
      end
   endtask

   task automatic send(input logic [1:0] op, input int x, input int y);
      int n = 0;
      while (!cmd_ready && n < 2000) begin
         step();
         n++;
      end
      if (!cmd_ready) chk(K_EQ, "ready_wait_timeout", 1, 0);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_x     = 3'(x);
      cmd_y     = 3'(y);
      step();
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
   endtask

   // Counts cycles from the first cycle after acceptance until ready returns.
   task automatic wait_ready(output int n);
      n = 1;
      while (!cmd_ready && n < 50) begin
         step();
         n++;
      end
   endtask

   task automatic wait_not_busy(output int n);
      n = 0;
      while (busy && n < 5000) begin
         step();
         n++;
      end
   endtask

   task automatic set_rd(input int x, input int y);
      rd_x = 3'(x);
      rd_y = 3'(y);
   endtask

   task automatic sweep_mines(output int cnt);
      cnt = 0;
      for (int y = 0; y < 8; y++) begin
         for (int x = 0; x < 8; x++) begin
            set_rd(x, y);
            #1;
            mine_map[y][x] = int'(rd_cell[4]);
            revd[y][x]     = 0;
            cnt += mine_map[y][x];
         end
      end
   endtask

   task automatic count_cells(input logic [6:0] mask, output int cnt);
      cnt = 0;
      for (int y = 0; y < 8; y++) begin
         for (int x = 0; x < 8; x++) begin
            set_rd(x, y);
            #1;
            if ((rd_cell & mask) != 7'd0) cnt++;
         end
      end
   endtask

   function automatic int nb_count(input int x, input int y);
      int c = 0;
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < 8 && y + dy >= 0 && y + dy < 8)
               c += mine_map[y + dy][x + dx];
         end
      end
      return c;
   endfunction

   function automatic int cval(input int rv, input int fl, input int mn, input int cnt);
      return rv * 64 + fl * 32 + mn * 16 + cnt;
   endfunction

   task automatic pick_safe(input int px, input int py, output int ox, output int oy);
      ox = -1; oy = -1;
      if (mine_map[py][px] == 0 && revd[py][px] == 0) begin
         ox = px; oy = py;
      end else begin
         for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
               if (ox < 0 && mine_map[y][x] == 0 && revd[y][x] == 0) begin
                  ox = x; oy = y;
               end
      end
   endtask

   task automatic pick_mine(output int ox, output int oy);
      ox = 0; oy = 0;
      for (int y = 7; y >= 0; y--)
         for (int x = 7; x >= 0; x--)
            if (mine_map[y][x] != 0) begin
               ox = x; oy = y;
            end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n, cnt, ix, iy, cx, cy, fx, fy, mx, my, safe_left;

      // Reset state
      repeat (3) step();
      chk(K_STATE, "reset_state", 0);
      chk(K_READY, "reset_ready", 1);
      chk(K_BUSY,  "reset_busy", 0);
      chk(K_FLAGS, "reset_flags", 10);
      drain();
      count_cells(7'h7F, cnt);
      chk(K_EQ, "reset_cells_nonzero", 0, cnt);
      drain();
      rst = 1'b1;
      step();

      // New game
      send(OP_NEW_GAME, 0, 0);
      wait_not_busy(n);
      chk(K_GE, "newgame_busy_cycles", 74, n);
      chk(K_STATE, "newgame_state", 1);
      chk(K_FLAGS, "newgame_flags", 10);
      drain();
      sweep_mines(cnt);
      chk(K_EQ, "newgame_mine_count", 10, cnt);
      drain();

      // Interior reveal
      pick_safe(3, 3, ix, iy);
      send(OP_REVEAL, ix, iy);
      wait_ready(n);
      chk(K_EQ, "interior_reveal_latency", 10, n);
      chk(K_STATE, "interior_state", 1);
      set_rd(ix, iy);
      chk(K_CELL, "interior_cell", cval(1, 0, 0, nb_count(ix, iy)));
      drain();
      revd[iy][ix] = 1;

      // Corner reveal (first safe corner)
      cx = -1; cy = -1;
      for (int c = 0; c < 4; c++) begin
         if (cx < 0 && mine_map[(c & 2) ? 7 : 0][(c & 1) ? 7 : 0] == 0) begin
            cx = (c & 1) ? 7 : 0;
            cy = (c & 2) ? 7 : 0;
         end
      end
      if (cx >= 0) begin
         send(OP_REVEAL, cx, cy);
         wait_ready(n);
         chk(K_EQ, "corner_reveal_latency", 10, n);
         set_rd(cx, cy);
         chk(K_CELL, "corner_cell", cval(1, 0, 0, nb_count(cx, cy)));
         drain();
         revd[cy][cx] = 1;
      end

      // Flag, reveal-while-flagged, unflag
      pick_safe(2, 2, fx, fy);
      set_rd(fx, fy);
      send(OP_FLAG, fx, fy);
      chk(K_READY, "flag_ready", 1);
      chk(K_FLAGS, "flag_flags_left", 9);
      chk(K_CELL,  "flag_cell_set", cval(0, 1, 0, 0));
      drain();
      send(OP_REVEAL, fx, fy);
      chk(K_READY, "flagged_reveal_ready", 1);
      chk(K_STATE, "flagged_reveal_state", 1);
      chk(K_CELL,  "flagged_reveal_cell", cval(0, 1, 0, 0));
      drain();
      send(OP_FLAG, fx, fy);
      chk(K_FLAGS, "unflag_flags_left", 10);
      chk(K_CELL,  "unflag_cell", cval(0, 0, 0, 0));
      drain();

      // Flag on a revealed cell is ignored
      set_rd(ix, iy);
      send(OP_FLAG, ix, iy);
      chk(K_FLAGS, "flag_revealed_flags_left", 10);
      chk(K_CELL,  "flag_revealed_cell", cval(1, 0, 0, nb_count(ix, iy)));
      drain();

      // 11 flags drive flags_left negative, then clear them
      cnt = 0;
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 8; x++)
            if (revd[y][x] == 0 && cnt < 11) begin
               send(OP_FLAG, x, y);
               cnt++;
            end
      chk(K_FLAGS, "flags_left_negative", 255);
      drain();
      cnt = 0;
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 8; x++)
            if (revd[y][x] == 0 && cnt < 11) begin
               send(OP_FLAG, x, y);
               cnt++;
            end
      chk(K_FLAGS, "flags_left_restored", 10);
      drain();

      // Reveal a mine -> LOST next cycle
      pick_mine(mx, my);
      set_rd(mx, my);
      send(OP_REVEAL, mx, my);
      chk(K_STATE, "mine_reveal_state", 3);
      chk(K_CELL,  "mine_reveal_cell", cval(1, 0, 1, 0));
      chk(K_READY, "mine_reveal_ready", 1);
      drain();

      // Commands after loss are ignored
      pick_safe(0, 0, fx, fy);
      set_rd(fx, fy);
      send(OP_REVEAL, fx, fy);
      send(OP_FLAG, fx, fy);
      chk(K_STATE, "lost_reveal_state", 3);
      chk(K_CELL,  "lost_reveal_cell", cval(0, 0, 0, 0));
      chk(K_FLAGS, "lost_flag_flags_left", 10);
      drain();

      // Restart
      send(OP_NEW_GAME, 0, 0);
      wait_not_busy(n);
      chk(K_GE, "restart_busy_cycles", 74, n);
      chk(K_STATE, "restart_state", 1);
      chk(K_FLAGS, "restart_flags", 10);
      drain();
      count_cells(7'h60, cnt);
      chk(K_EQ, "restart_revealed_or_flagged", 0, cnt);
      sweep_mines(cnt);
      chk(K_EQ, "restart_mine_count", 10, cnt);
      drain();

      // Reveal every safe cell -> WON after the last write
      safe_left = 54;
      for (int y = 0; y < 8; y++) begin
         for (int x = 0; x < 8; x++) begin
            if (mine_map[y][x] == 0) begin
               set_rd(x, y);
               send(OP_REVEAL, x, y);
               wait_ready(n);
               safe_left--;
               chk(K_CELL, "win_cell", cval(1, 0, 0, nb_count(x, y)));
               chk(K_STATE, "win_progress_state", (safe_left == 0) ? 2 : 1);
               drain();
            end
         end
      end
      chk(K_STATE, "won_state", 2);
      chk(K_READY, "won_ready", 1);
      drain();

      // Reset asserted during a SCAN
      send(OP_NEW_GAME, 0, 0);
      wait_not_busy(n);
      sweep_mines(cnt);
      pick_mine(mx, my);
      send(OP_FLAG, mx, my);
      pick_safe(4, 4, fx, fy);
      send(OP_REVEAL, fx, fy);
      step();
      step();
      chk(K_BUSY, "scan_busy", 1);
      drain();
      rst = 1'b0;
      #1;
      set_rd(fx, fy);
      chk(K_STATE, "abort_state", 0);
      chk(K_READY, "abort_ready", 1);
      chk(K_BUSY,  "abort_busy", 0);
      chk(K_FLAGS, "abort_flags", 10);
      chk(K_CELL,  "abort_target_cell", 0);
      drain();
      count_cells(7'h7F, cnt);
      chk(K_EQ, "abort_cells_nonzero", 0, cnt);
      drain();
      rst = 1'b1;
      repeat (12) step();
      chk(K_CELL,  "post_abort_target_cell", 0);
      chk(K_STATE, "post_abort_state", 0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
